stack_access_ctrl: RTL and testbench
====================================

// Module: stack_access_ctrl
// PURPOSE
//  Upstream command front-end for the 16-entry LIFO stack block.
//  Accepts push/pop commands on a valid/ready channel and tracks occupancy.
//  Blocks overflow and underflow before they reach the stack.
//  Issues single-cycle stk_push/stk_pop strobes, captures popped data and
//  returns one response per command on a valid/ready channel.
// PARAMETERS
//  DATA_W  8   data width; must match the stack data width
//  DEPTH   16  stack capacity in entries
//  LVL_W   5   width of level; must satisfy 2**LVL_W > DEPTH
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//  cmd_op     in   1       0 = push, 1 = pop
//  cmd_data   in   DATA_W  push data (ignored for pop)
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       response consumed when rsp_valid & rsp_ready
//  rsp_data   out  DATA_W  pop: popped value; push: echo of pushed value; error: 0
//  rsp_err    out  1       1 = command rejected (overflow or underflow)
//  stk_push   out  1       push strobe to stack, one cycle
//  stk_pop    out  1       pop strobe to stack, one cycle
//  stk_din    out  DATA_W  data to stack, valid while stk_push = 1
//  stk_dout   in   DATA_W  stack read data; registered, valid one cycle after stk_pop
//  level      out  LVL_W   current occupancy, 0..DEPTH
//  full       out  1       level == DEPTH
//  empty      out  1       level == 0
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: state = IDLE; cmd_ready = 1; rsp_valid = 0; rsp_data = 0;
//    rsp_err = 0; stk_push = 0; stk_pop = 0; stk_din = 0; level = 0;
//    empty = 1; full = 0.
//  - FSM states: IDLE, PUSH, POP, WAIT, ERR, RESP.
//    - cmd_ready = 1 only in IDLE; one command is in flight at a time.
//  - IDLE, on accept:
//    - push & !full  -> PUSH; latch cmd_data into stk_din.
//    - pop & !empty  -> POP.
//    - push & full, or pop & empty -> ERR.
//  - PUSH: stk_push = 1 for exactly this cycle; level += 1.
//    Set rsp_data = stk_din, rsp_err = 0; go to RESP.
//  - POP: stk_pop = 1 for exactly this cycle; level -= 1; go to WAIT.
//  - WAIT: no strobes; rsp_data <= stk_dout at the end of the cycle; go to RESP.
//  - ERR: no strobes; level unchanged; rsp_data = 0, rsp_err = 1; go to RESP.
//  - RESP: rsp_valid = 1, held with data/err stable until rsp_ready.
//    - On handshake: rsp_valid = 0, go to IDLE.
//    - cmd_ready rises in the cycle after the handshake.
//  - Latency from accept edge T:
//    - push: stk_push high in T+1; rsp_valid from T+2.
//    - pop: stk_pop high in T+1; rsp_valid from T+3.
//    - error: rsp_valid from T+2.
//  - full and empty update in the same cycle as level.
//    level never exceeds DEPTH and never wraps below 0.
//  - stk_push and stk_pop are never high together.
//  - rst mid-operation: abort any in-flight command; no response is produced.
//    rst must reset the stack in the same cycle so occupancy stays coherent.
//  - cmd_op and cmd_data are sampled only on an accepted command.
// CONFIGURATION
//  STACK_CTRL_ERRCNT_EN defined:
//    - Adds output err_cnt[7:0], reset 0.
//    - err_cnt increments on each ERR entry and saturates at 255.
//    - Adds input err_clr: synchronous clear, takes priority over increment.
//  STACK_CTRL_ERRCNT_EN undefined:
//    - err_cnt and err_clr ports are absent; no counter logic.
// TESTING
//  1 Reset, then push 0xA5 with rsp_ready = 1 -> stk_push one cycle with stk_din = 0xA5;
//    rsp_valid/rsp_data = 0xA5, err = 0; level = 1, empty = 0.
//  2 Push 0x11, 0x22, 0x33, then pop x3 -> rsp_data 0x33, 0x22, 0x11 in order;
//    level = 0, empty = 1.
//  3 Pop on empty -> no stk_pop; rsp_err = 1, rsp_data = 0; level stays 0;
//    err_cnt = 1 if macro defined.
//  4 Push 16 values 0x00..0x0F -> full = 1; 17th push gives rsp_err = 1 with no stk_push;
//    next pop returns 0x0F.
//  5 Hold rsp_ready = 0 for 5 cycles after a pop -> rsp_valid/rsp_data stable and
//    cmd_ready = 0 throughout; accept resumes the cycle after the handshake.
//  6 Assert rst in a POP/WAIT cycle -> all outputs return to reset values at once;
//    no response is emitted.

Source files
------------

// File: rtl/stack_access_ctrl.sv
// Command front-end for a LIFO stack: guards overflow/underflow, strobes the stack, returns one response per command.
// Optional error counter (err_cnt/err_clr) enabled by defining STACK_CTRL_ERRCNT_EN.
module stack_access_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LVL_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
`ifdef STACK_CTRL_ERRCNT_EN
  ,
  input  logic              err_clr,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, PUSH, POP, WAIT, ERR, RESP} state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                stk_push_q, stk_push_d;
  logic                stk_pop_q, stk_pop_d;
  logic [DATA_W-1:0]   stk_din_q, stk_din_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                accept_c;

  assign accept_c = cmd_valid & cmd_ready_q;

  // Next state; outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    state_d    = state_q;
    stk_din_d  = stk_din_q;
    level_d    = level_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (!cmd_op) begin
            if (full_q) begin
              state_d = ERR;
            end else begin
              state_d   = PUSH;
              stk_din_d = cmd_data;
              level_d   = level_q + LVL_W'(1);
            end
          end else begin
            if (empty_q) begin
              state_d = ERR;
            end else begin
              state_d = POP;
              level_d = level_q - LVL_W'(1);
            end
          end
        end
      end
      PUSH: begin
        rsp_data_d = stk_din_q;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      POP: begin
        state_d = WAIT;
      end
      // Stack read data is registered, so it is valid during this cycle.
      WAIT: begin
        rsp_data_d = stk_dout;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
      end
      ERR: begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    stk_push_d  = (state_d == PUSH);
    stk_pop_d   = (state_d == POP);
    full_d      = (level_d == LVL_W'(DEPTH));
    empty_d     = (level_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_din_q   <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      stk_push_q  <= stk_push_d;
      stk_pop_q   <= stk_pop_d;
      stk_din_q   <= stk_din_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stk_push  = stk_push_q;
  assign stk_pop   = stk_pop_q;
  assign stk_din   = stk_din_q;
  assign level     = level_q;
  assign full      = full_q;
  assign empty     = empty_q;

`ifdef STACK_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts rejected commands on ERR entry; clear wins, count saturates.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if ((state_q == IDLE) && (state_d == ERR) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Directed self-checking bench for stack_access_ctrl, with a behavioural 16-entry stack behind it.
module tb_stack_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;
  logic [4:0] level;
  logic       full;
  logic       empty;
`ifdef STACK_CTRL_ERRCNT_EN
  logic       err_clr;
  logic [7:0] err_cnt;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  stack_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .level     (level),
    .full      (full),
    .empty     (empty)
`ifdef STACK_CTRL_ERRCNT_EN
    ,
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
`endif
  );

  // Stack model: registered read data, reset together with the controller.
  logic [7:0] mem [16];
  int         sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= 0;
      stk_dout <= 8'h00;
    end else begin
      if (stk_push && sp < 16) begin
        mem[sp] <= stk_din;
        sp      <= sp + 1;
      end
      if (stk_pop && sp > 0) begin
        stk_dout <= mem[sp-1];
        sp       <= sp - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with rsp_ready held high; checks strobe timing, response and final occupancy.
  task automatic do_cmd(input logic op, input logic [7:0] din, input logic exp_err,
                        input logic [7:0] exp_data, input logic [4:0] exp_level);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = din;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    cmd_data  = 8'hEE;
    chk("stk_push_t1", 32'(stk_push), 32'(!exp_err && !op));
    chk("stk_pop_t1", 32'(stk_pop), 32'(!exp_err && op));
    if (!exp_err && !op) chk("stk_din_t1", 32'(stk_din), 32'(din));
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    chk("rsp_valid_t1", 32'(rsp_valid), 32'd0);
    if (op && !exp_err) begin
      step();
      chk("rsp_valid_wait", 32'(rsp_valid), 32'd0);
      chk("stk_pop_once", 32'(stk_pop), 32'd0);
    end
    step();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp_data));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("strobes_idle", 32'({stk_push, stk_pop}), 32'd0);
    step();
    chk("rsp_valid_done", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("level", 32'(level), 32'(exp_level));
    chk("full", 32'(full), 32'(exp_level == 5'd16));
    chk("empty", 32'(empty), 32'(exp_level == 5'd0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;
`ifdef STACK_CTRL_ERRCNT_EN
    err_clr   = 1'b0;
`endif
    step();
    step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_strobes", 32'({stk_push, stk_pop}), 32'd0);
    chk("rst_stk_din", 32'(stk_din), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty_full", 32'({empty, full}), 32'b10);
    rst = 1'b0;
    step();

    // Single push
    do_cmd(1'b0, 8'hA5, 1'b0, 8'hA5, 5'd1);

    // LIFO order
    do_cmd(1'b0, 8'h11, 1'b0, 8'h11, 5'd2);
    do_cmd(1'b0, 8'h22, 1'b0, 8'h22, 5'd3);
    do_cmd(1'b0, 8'h33, 1'b0, 8'h33, 5'd4);
    do_cmd(1'b1, 8'h00, 1'b0, 8'h33, 5'd3);
    do_cmd(1'b1, 8'h00, 1'b0, 8'h22, 5'd2);
    do_cmd(1'b1, 8'h00, 1'b0, 8'h11, 5'd1);
    do_cmd(1'b1, 8'h00, 1'b0, 8'hA5, 5'd0);

    // Underflow
    do_cmd(1'b1, 8'h00, 1'b1, 8'h00, 5'd0);
`ifdef STACK_CTRL_ERRCNT_EN
    chk("err_cnt_underflow", 32'(err_cnt), 32'd1);
`endif

    // Fill, then overflow
    for (int i = 0; i < 16; i++) begin
      do_cmd(1'b0, 8'(i), 1'b0, 8'(i), 5'(i + 1));
    end
    do_cmd(1'b0, 8'h99, 1'b1, 8'h00, 5'd16);
`ifdef STACK_CTRL_ERRCNT_EN
    chk("err_cnt_overflow", 32'(err_cnt), 32'd2);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif
    do_cmd(1'b1, 8'h00, 1'b0, 8'h0F, 5'd15);

    // Response back-pressure with a pending command waiting
    rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("bp_stk_pop", 32'(stk_pop), 32'd1);
    step();
    step();
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h0E);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_no_push", 32'(stk_push), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("bp_resume_push", 32'(stk_push), 32'd1);
    chk("bp_resume_din", 32'(stk_din), 32'h77);
    step();
    chk("bp_resume_rsp", 32'(rsp_data), 32'h77);
    step();
    chk("bp_level", 32'(level), 32'd15);

    // Reset during a pop
    cmd_valid = 1'b1;
    cmd_op    = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("rp_stk_pop", 32'(stk_pop), 32'd1);
    chk("rp_level", 32'(level), 32'd14);
    rst = 1'b1;
    #1;
    chk("rp_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rp_strobes", 32'({stk_push, stk_pop}), 32'd0);
    chk("rp_rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'd0);
    chk("rp_stk_din", 32'(stk_din), 32'd0);
    chk("rp_level0", 32'(level), 32'd0);
    chk("rp_empty_full", 32'({empty, full}), 32'b10);
`ifdef STACK_CTRL_ERRCNT_EN
    chk("rp_err_cnt", 32'(err_cnt), 32'd0);
`endif
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rp_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_cmd(1'b1, 8'h00, 1'b1, 8'h00, 5'd0);
    do_cmd(1'b0, 8'h5A, 1'b0, 8'h5A, 5'd1);
    do_cmd(1'b1, 8'h00, 1'b0, 8'h5A, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
